conn_route_table: RTL and testbench

CONN_ROUTE_TABLE -- requirements
Module: conn_route_table

---
 rtl/lynxTypes.sv | 24 ++
 rtl/conn_route_lookup_port.sv | 37 +++
 rtl/conn_route_table.sv | 153 +++++++++++++++
 tb/tb_conn_route_table.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lynxTypes.sv
// Shared types for the connection route table: route_id layout, FSM states and saturating arithmetic.
package lynxTypes;

    localparam int unsigned ROUTE_ID_BITS = 14;

    typedef struct packed {
        logic [3:0] rsvd;
        logic [3:0] sender_id;
        logic [3:0] receiver_id;
        logic [1:0] flags;
    } route_id_t;

    typedef enum logic {
        ST_FLUSH = 1'b0,
        ST_IDLE  = 1'b1
    } tbl_state_e;

    function automatic logic [31:0] sat_add32(input logic [31:0] base, input logic [31:0] inc);
        logic [32:0] sum;
        sum = {1'b0, base} + {1'b0, inc};
        return sum[32] ? '1 : sum[31:0];
    endfunction

endpackage

// File: rtl/conn_route_lookup_port.sv
// One lookup channel: request/response handshake and the registered response fields.
module conn_route_lookup_port
    import lynxTypes::*;
(
    input  logic      aclk,
    input  logic      aresetn,
    input  logic      in_idle,
    input  logic      req_valid,
    output logic      req_ready,
    output logic      accept,
    input  logic      lkp_hit,
    input  route_id_t lkp_route_id,
    output logic      rsp_valid,
    input  logic      rsp_ready,
    output logic      rsp_hit,
    output route_id_t rsp_route_id
);

    assign req_ready = in_idle & (~rsp_valid | rsp_ready);
    assign accept    = req_valid & req_ready;

    // Response fields only move on a new acceptance, so they hold while stalled.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            rsp_valid    <= 1'b0;
            rsp_hit      <= 1'b0;
            rsp_route_id <= '0;
        end else if (accept) begin
            rsp_valid    <= 1'b1;
            rsp_hit      <= lkp_hit;
            rsp_route_id <= lkp_route_id;
        end else if (rsp_ready) begin
            rsp_valid    <= 1'b0;
        end
    end

endmodule

// File: rtl/conn_route_table.sv
// Connection-indexed route table with N_CH lookup channels, write-first bypass and a flush sweep.
module conn_route_table
    import lynxTypes::*;
#(
    parameter int unsigned NUM_ENTRIES = 256,
    parameter int unsigned N_CH        = 2,
    parameter int unsigned INDEX_BITS  = $clog2(NUM_ENTRIES)
)(
    input  logic                            aclk,
    input  logic                            aresetn,
    input  logic                            wr_en,
    input  logic                            wr_clr,
    input  logic [INDEX_BITS-1:0]           wr_index,
    input  logic [ROUTE_ID_BITS-1:0]        wr_route_id,
    input  logic                            flush,
    output logic                            busy,
    input  logic [N_CH-1:0]                 req_valid,
    output logic [N_CH-1:0]                 req_ready,
    input  logic [N_CH*INDEX_BITS-1:0]      req_index,
    output logic [N_CH-1:0]                 rsp_valid,
    input  logic [N_CH-1:0]                 rsp_ready,
    output logic [N_CH*ROUTE_ID_BITS-1:0]   rsp_route_id,
    output logic [N_CH-1:0]                 rsp_hit,
    output logic [31:0]                     miss_count
);

    localparam logic [INDEX_BITS-1:0] LAST_IDX = INDEX_BITS'(NUM_ENTRIES - 1);

    tbl_state_e              state_q, state_d;
    logic [INDEX_BITS-1:0]   sweep_q, sweep_d;
    logic                    in_idle;
    logic                    wr_act;

    logic [NUM_ENTRIES-1:0]  valid_q;
    route_id_t               route_mem [NUM_ENTRIES];

    logic [N_CH-1:0]         accept_vec;
    logic [N_CH-1:0]         miss_vec;
    logic [31:0]             miss_inc;
    logic [31:0]             miss_count_q;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q <= ST_FLUSH;
            sweep_q <= '0;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        case (state_q)
            ST_FLUSH: begin
                if (flush) begin
                    sweep_d = '0;
                end else if (sweep_q == LAST_IDX) begin
                    state_d = ST_IDLE;
                end else begin
                    sweep_d = sweep_q + INDEX_BITS'(1);
                end
            end
            ST_IDLE: begin
                if (flush) begin
                    state_d = ST_FLUSH;
                    sweep_d = '0;
                end
            end
            default: begin
                state_d = ST_FLUSH;
                sweep_d = '0;
            end
        endcase
    end

    always_comb begin
        busy    = (state_q == ST_FLUSH);
        in_idle = (state_q == ST_IDLE);
        wr_act  = in_idle & aresetn & wr_en;
    end

    // Valid bits carry no reset; the post-reset sweep clears them before lookups open.
    always_ff @(posedge aclk) begin
        if (!in_idle) begin
            valid_q[sweep_q] <= 1'b0;
        end else if (wr_act) begin
            valid_q[wr_index] <= ~wr_clr;
        end
    end

    always_ff @(posedge aclk) begin
        if (wr_act && !wr_clr) begin
            route_mem[wr_index] <= route_id_t'(wr_route_id);
        end
    end

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        logic [INDEX_BITS-1:0] idx;
        logic                  byp;
        logic                  hit_k;
        route_id_t             id_k;

        assign idx = req_index[k*INDEX_BITS +: INDEX_BITS];
        assign byp = wr_act && (wr_index == idx);

        // A same-cycle write to the looked-up index wins over the stored entry.
        always_comb begin
            hit_k = valid_q[idx];
            id_k  = valid_q[idx] ? route_mem[idx] : '0;
            if (byp) begin
                hit_k = ~wr_clr;
                id_k  = wr_clr ? '0 : route_id_t'(wr_route_id);
            end
        end

        assign miss_vec[k] = accept_vec[k] & ~hit_k;

        conn_route_lookup_port u_port (
            .aclk         (aclk),
            .aresetn      (aresetn),
            .in_idle      (in_idle),
            .req_valid    (req_valid[k]),
            .req_ready    (req_ready[k]),
            .accept       (accept_vec[k]),
            .lkp_hit      (hit_k),
            .lkp_route_id (id_k),
            .rsp_valid    (rsp_valid[k]),
            .rsp_ready    (rsp_ready[k]),
            .rsp_hit      (rsp_hit[k]),
            .rsp_route_id (rsp_route_id[k*ROUTE_ID_BITS +: ROUTE_ID_BITS])
        );
    end

    always_comb begin
        miss_inc = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            miss_inc = miss_inc + 32'(miss_vec[i]);
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            miss_count_q <= '0;
        end else begin
            miss_count_q <= sat_add32(miss_count_q, miss_inc);
        end
    end

    assign miss_count = miss_count_q;

endmodule

// File: tb/tb_conn_route_table.sv
// Randomized bench for conn_route_table checked every cycle against a table-level reference model.
module tb_conn_route_table;

    localparam int NE = 256;
    localparam int IB = 8;
    localparam int RB = 14;

    logic            aclk;
    logic            aresetn;
    logic            wr_en;
    logic            wr_clr;
    logic [IB-1:0]   wr_index;
    logic [RB-1:0]   wr_route_id;
    logic            flush;
    logic            busy;
    logic [1:0]      req_valid;
    logic [1:0]      req_ready;
    logic [2*IB-1:0] req_index;
    logic [1:0]      rsp_valid;
    logic [1:0]      rsp_ready;
    logic [2*RB-1:0] rsp_route_id;
    logic [1:0]      rsp_hit;
    logic [31:0]     miss_count;

    int errors = 0;
    int checks = 0;

    // Reference model: table contents, remaining sweep cycles, per-channel response register.
    bit          m_valid [NE];
    logic [RB-1:0] m_id  [NE];
    int          m_left = 256;
    bit          m_rv  [2];
    bit          m_hit [2];
    logic [RB-1:0] m_rid [2];
    logic [31:0] m_miss = '0;

    conn_route_table #(
        .NUM_ENTRIES (256),
        .N_CH        (2),
        .INDEX_BITS  (8)
    ) dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .wr_en        (wr_en),
        .wr_clr       (wr_clr),
        .wr_index     (wr_index),
        .wr_route_id  (wr_route_id),
        .flush        (flush),
        .busy         (busy),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_index    (req_index),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_route_id (rsp_route_id),
        .rsp_hit      (rsp_hit),
        .miss_count   (miss_count)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    always @(posedge aclk) begin
        bit idle;
        bit acc;
        int nmiss;
        int idx;
        if (!aresetn) begin
            m_left = 256;
            for (int i = 0; i < NE; i++) m_valid[i] = 1'b0;
            for (int k = 0; k < 2; k++) begin
                m_rv[k] = 1'b0; m_hit[k] = 1'b0; m_rid[k] = '0;
            end
            m_miss = '0;
        end else begin
            idle = (m_left == 0);
            if (idle && wr_en) begin
                if (wr_clr) m_valid[wr_index] = 1'b0;
                else begin
                    m_valid[wr_index] = 1'b1;
                    m_id[wr_index] = wr_route_id;
                end
            end
            nmiss = 0;
            for (int k = 0; k < 2; k++) begin
                acc = idle && req_valid[k] && (!m_rv[k] || rsp_ready[k]);
                if (acc) begin
                    idx = int'(req_index[k*IB +: IB]);
                    m_rv[k]  = 1'b1;
                    m_hit[k] = m_valid[idx];
                    m_rid[k] = m_valid[idx] ? m_id[idx] : '0;
                    if (!m_valid[idx]) nmiss++;
                end else if (rsp_ready[k]) begin
                    m_rv[k] = 1'b0;
                end
            end
            if (33'(m_miss) + 33'(nmiss) > 33'h0FFFFFFFF) m_miss = '1;
            else m_miss = m_miss + 32'(nmiss);
            if (!idle) begin
                m_left = flush ? 256 : m_left - 1;
            end else if (flush) begin
                m_left = 256;
                for (int i = 0; i < NE; i++) m_valid[i] = 1'b0;
            end
        end
    end

    always @(negedge aclk) begin
        chk("busy", 32'(busy), 32'(m_left > 0));
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("req_ready%0d", k), 32'(req_ready[k]),
                32'((m_left == 0) && (!m_rv[k] || rsp_ready[k])));
            chk($sformatf("rsp_valid%0d", k), 32'(rsp_valid[k]), 32'(m_rv[k]));
            chk($sformatf("rsp_hit%0d", k), 32'(rsp_hit[k]), 32'(m_hit[k]));
            chk($sformatf("rsp_route_id%0d", k), 32'(rsp_route_id[k*RB +: RB]), 32'(m_rid[k]));
        end
        chk("miss_count", miss_count, m_miss);
    end

    task automatic step();
        @(negedge aclk);
        #2;
    endtask

    task automatic idle_inputs();
        wr_en = 1'b0; wr_clr = 1'b0; flush = 1'b0;
        req_valid = 2'b00; rsp_ready = 2'b11;
    endtask

    task automatic wait_flush(output int n);
        n = 0;
        while (n < 400) begin
            @(negedge aclk);
            #2;
            n++;
            if (!busy) begin
                idle_inputs();
                break;
            end
        end
    endtask

    initial begin
        int n;
        aresetn = 1'b0;
        wr_index = '0; wr_route_id = '0; req_index = '0;
        idle_inputs();
        repeat (3) step();
        chk("reset_busy", 32'(busy), 32'd1);
        chk("reset_miss", miss_count, 32'd0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        aresetn = 1'b1;
        wait_flush(n);
        chk("reset_sweep_len", 32'(n), 32'd256);

        req_valid = 2'b01; req_index = {8'd0, 8'd5};
        step();
        req_valid = 2'b00;
        chk("miss5_valid", 32'(rsp_valid[0]), 32'd1);
        chk("miss5_hit", 32'(rsp_hit[0]), 32'd0);
        chk("miss5_id", 32'(rsp_route_id[13:0]), 32'd0);
        chk("miss5_count", miss_count, 32'd1);

        wr_en = 1'b1; wr_clr = 1'b0; wr_index = 8'd5; wr_route_id = 14'h0244;
        step();
        wr_en = 1'b0;
        req_valid = 2'b11; req_index = {8'd5, 8'd5};
        step();
        req_valid = 2'b00;
        chk("dual_hit", 32'(rsp_hit), 32'd3);
        chk("dual_id0", 32'(rsp_route_id[13:0]), 32'h0244);
        chk("dual_id1", 32'(rsp_route_id[27:14]), 32'h0244);

        wr_en = 1'b1; wr_clr = 1'b0; wr_index = 8'd9; wr_route_id = 14'h0111;
        req_valid = 2'b10; req_index = {8'd9, 8'd0};
        step();
        chk("byp_set_hit", 32'(rsp_hit[1]), 32'd1);
        chk("byp_set_id", 32'(rsp_route_id[27:14]), 32'h0111);
        wr_clr = 1'b1;
        step();
        wr_en = 1'b0; wr_clr = 1'b0; req_valid = 2'b00;
        chk("byp_clr_hit", 32'(rsp_hit[1]), 32'd0);
        chk("byp_clr_id", 32'(rsp_route_id[27:14]), 32'd0);
        chk("byp_miss", miss_count, 32'd2);

        rsp_ready = 2'b10; req_valid = 2'b01; req_index = {8'd0, 8'd5};
        step();
        req_index = {8'd0, 8'd9};
        for (int i = 0; i < 4; i++) begin
            step();
            chk("stall_ready", 32'(req_ready[0]), 32'd0);
            chk("stall_id", 32'(rsp_route_id[13:0]), 32'h0244);
            chk("stall_hit", 32'(rsp_hit[0]), 32'd1);
        end
        rsp_ready = 2'b11;
        step();
        chk("resume_hit9", 32'(rsp_hit[0]), 32'd0);
        req_index = {8'd0, 8'd5};
        step();
        req_valid = 2'b00;
        chk("resume_hit5", 32'(rsp_hit[0]), 32'd1);
        chk("resume_valid", 32'(rsp_valid[0]), 32'd1);

        wr_en = 1'b1; wr_index = 8'd3; wr_route_id = 14'h3ABC;
        step();
        wr_en = 1'b0; flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_busy", 32'(busy), 32'd1);
        chk("flush_ready", 32'(req_ready), 32'd0);
        wr_en = 1'b1; wr_index = 8'd7; wr_route_id = 14'h0077;
        req_valid = 2'b01; req_index = {8'd0, 8'd3};
        wait_flush(n);
        chk("flush_len", 32'(n), 32'd256);
        req_valid = 2'b11; req_index = {8'd7, 8'd3};
        step();
        req_valid = 2'b00;
        chk("post_flush_hit", 32'(rsp_hit), 32'd0);

        force dut.miss_count_q = 32'hFFFFFFFE;
        m_miss = 32'hFFFFFFFE;
        #1;
        release dut.miss_count_q;
        req_valid = 2'b11;
        step();
        chk("sat_first", miss_count, 32'hFFFFFFFF);
        step();
        req_valid = 2'b00;
        chk("sat_hold", miss_count, 32'hFFFFFFFF);

        rsp_ready = 2'b00; req_valid = 2'b11; req_index = {8'd3, 8'd3};
        step();
        chk("pend_valid", 32'(rsp_valid), 32'd3);
        aresetn = 1'b0;
        req_valid = 2'b00;
        repeat (2) step();
        chk("mid_reset_valid", 32'(rsp_valid), 32'd0);
        chk("mid_reset_miss", miss_count, 32'd0);
        chk("mid_reset_busy", 32'(busy), 32'd1);
        aresetn = 1'b1;
        idle_inputs();

        for (int c = 0; c < 3000; c++) begin
            wr_en       = ($urandom_range(0, 3) == 0);
            wr_clr      = ($urandom_range(0, 2) == 0);
            wr_index    = 8'($urandom_range(0, 15));
            wr_route_id = 14'($urandom);
            req_valid   = 2'($urandom);
            req_index   = {8'($urandom_range(0, 15)), 8'($urandom_range(0, 15))};
            rsp_ready   = {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)};
            flush       = ($urandom_range(0, 599) == 0);
            step();
        end
        idle_inputs();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
